// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared types and default widths for the DRAM burst arbiter
// Contents:
//   DEF_COL_NUM / DEF_ADDR_W / DEF_LEN_W : default data, address and burst-length widths
//   arb_state_t                          : sequencer state (IDLE, BURST, DONE)
//   burst_desc_t                         : burst descriptor {wr, addr, len}
package dram_arbiter_pkg;

  localparam int DEF_COL_NUM = 128;
  localparam int DEF_ADDR_W  = 25;
  localparam int DEF_LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_LEN_W-1:0]  len;
  } burst_desc_t;

endpackage

// File: rtl/dram_arbiter_rr_arb2.sv
// rtl/dram_arbiter_rr_arb2.sv - two-way round-robin grant selector
// Ports:
//   req  in  2  request vector
//   last in  1  index of the most recently granted requester
//   gnt  out 2  one-hot grant (zero when no request)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // On a tie, the requester that did not win last time goes first.
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-requester round-robin burst sequencer for a single-port DRAM
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req, req_wr, req_addr, req_len  burst request and descriptor per requester
//   gnt                           one-cycle pulse when requester i's descriptor is captured
//   wdata, wvalid, wready         write beat handshake per requester
//   rdata, rvalid                 registered read beat toward the owner
//   done                          one-cycle pulse after the last beat of a burst
//   DRAM_*                        single-port DRAM access interface
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int COL_NUM = DEF_COL_NUM,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0]           req_wr,
  input  logic [2*ADDR_W-1:0]  req_addr,
  input  logic [2*LEN_W-1:0]   req_len,
  output logic [1:0]           gnt,
  input  logic [2*COL_NUM-1:0] wdata,
  input  logic [1:0]           wvalid,
  output logic [1:0]           wready,
  output logic [COL_NUM-1:0]   rdata,
  output logic [1:0]           rvalid,
  output logic [1:0]           done,
  output logic                 DRAM_valid,
  output logic                 DRAM_wr_en,
  output logic [ADDR_W-1:0]    DRAM_addr,
  input  logic [COL_NUM-1:0]   DRAM_rd_data,
  output logic [COL_NUM-1:0]   DRAM_wr_data
);

  arb_state_t          state, state_nxt;
  logic                owner;
  logic                rr_last;
  logic                desc_wr;
  logic [ADDR_W-1:0]   desc_addr;
  logic [LEN_W-1:0]    desc_len;
  logic [LEN_W-1:0]    beat_cnt;
  logic [COL_NUM-1:0]  wr_data_q;

  logic [1:0]          arb_gnt;
  logic                win;
  logic                owner_wvalid;
  logic [COL_NUM-1:0]  owner_wdata;
  logic                beat_fire;
  logic                last_beat;

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (rr_last),
    .gnt  (arb_gnt)
  );

  assign win          = arb_gnt[1];
  assign owner_wvalid = owner ? wvalid[1] : wvalid[0];
  assign owner_wdata  = owner ? wdata[2*COL_NUM-1:COL_NUM] : wdata[COL_NUM-1:0];

  // Reads issue every burst cycle; writes only when the owner has a beat ready.
  assign beat_fire = (state == BURST) && (desc_wr ? owner_wvalid : 1'b1);
  assign last_beat = beat_fire && (beat_cnt == desc_len);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = BURST;
      BURST:   if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt          = (state == IDLE) ? arb_gnt : 2'b00;
    DRAM_valid   = beat_fire;
    DRAM_wr_en   = (state == BURST) && desc_wr;
    // beat_cnt is not advanced on the last beat, so the address holds afterwards.
    DRAM_addr    = desc_addr + {{(ADDR_W-LEN_W){1'b0}}, beat_cnt};
    DRAM_wr_data = ((state == BURST) && desc_wr) ? owner_wdata : wr_data_q;
    wready       = 2'b00;
    if ((state == BURST) && desc_wr) wready[owner] = owner_wvalid;
    done         = 2'b00;
    if (state == DONE) done[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_last   <= 1'b1;
      desc_wr   <= 1'b0;
      desc_addr <= '0;
      desc_len  <= '0;
      beat_cnt  <= '0;
      wr_data_q <= '0;
      rdata     <= '0;
      rvalid    <= 2'b00;
    end else begin
      state  <= state_nxt;
      rvalid <= 2'b00;
      if ((state == IDLE) && (|req)) begin
        owner     <= win;
        rr_last   <= win;
        desc_wr   <= win ? req_wr[1] : req_wr[0];
        desc_addr <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        desc_len  <= win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
        beat_cnt  <= '0;
      end
      if (beat_fire && !last_beat) beat_cnt <= beat_cnt + 1'b1;
      if (beat_fire && desc_wr) wr_data_q <= owner_wdata;
      if (beat_fire && !desc_wr) begin
        rdata  <= DRAM_rd_data;
        rvalid <= {owner, ~owner};
      end
    end
  end

endmodule
